// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared defaults and FSM state type for the matrix term issuer
package matrix_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_VAR_WIDTH  = 8;
    localparam int DEF_M_SIZE     = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/matrix_index_counter.sv
// rtl/matrix_index_counter.sv - nested k/col/row counter walking an M_SIZE^3 operand stream
module matrix_index_counter
    import matrix_pkg::*;
#(
    parameter  int M_SIZE = DEF_M_SIZE,
    localparam int IW     = $clog2(M_SIZE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          step,
    output logic [IW-1:0] k,
    output logic [IW-1:0] col,
    output logic [IW-1:0] row,
    output logic          last_k,
    output logic          last_all
);

    logic [IW-1:0] r_k;
    logic [IW-1:0] r_col;
    logic [IW-1:0] r_row;
    logic          w_last_col;
    logic          w_last_row;

    assign w_last_col = (r_col == IW'(M_SIZE - 1));
    assign w_last_row = (r_row == IW'(M_SIZE - 1));
    assign last_k     = (r_k == IW'(M_SIZE - 1));
    assign last_all   = last_k && w_last_col && w_last_row;
    assign k          = r_k;
    assign col        = r_col;
    assign row        = r_row;

    // Explicit wrap compare keeps non-power-of-two sizes correct
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_k   <= '0;
            r_col <= '0;
            r_row <= '0;
        end else if (clear) begin
            r_k   <= '0;
            r_col <= '0;
            r_row <= '0;
        end else if (step) begin
            if (last_k) begin
                r_k <= '0;
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + IW'(1);
                end else begin
                    r_col <= r_col + IW'(1);
                end
            end else begin
                r_k <= r_k + IW'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_term_issuer.sv
// rtl/matrix_term_issuer.sv - streams A/B operand pairs as product terms into an external accumulator
module matrix_term_issuer
    import matrix_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int VAR_WIDTH  = DEF_VAR_WIDTH,
    parameter  int M_SIZE     = DEF_M_SIZE,
    localparam int IW         = $clog2(M_SIZE)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  op_valid,
    input  logic [VAR_WIDTH-1:0]  a_data,
    input  logic [VAR_WIDTH-1:0]  b_data,
    output logic                  op_ready,
    output logic                  clear,
    output logic                  enable,
    output logic                  listo,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  dot_valid,
    output logic [IW-1:0]         row_idx,
    output logic [IW-1:0]         col_idx,
    output logic                  busy,
    output logic                  done
);

    state_t                r_state;
    logic                  r_op_ready;
    logic                  r_clear;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_enable;
    logic                  r_listo;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_iss_last;
    logic [IW-1:0]         r_iss_row;
    logic [IW-1:0]         r_iss_col;
    logic                  r_dly_last;
    logic [IW-1:0]         r_dly_row;
    logic [IW-1:0]         r_dly_col;
    logic                  r_dot_valid;
    logic [IW-1:0]         r_row_idx;
    logic [IW-1:0]         r_col_idx;

    logic                  w_accept;
    logic                  w_cnt_clear;
    logic [IW-1:0]         w_k;
    logic [IW-1:0]         w_col;
    logic [IW-1:0]         w_row;
    logic                  w_last_k;
    logic                  w_last_all;
    logic                  w_final_dot;
    logic [DATA_WIDTH-1:0] w_product;

    assign w_accept    = op_valid && r_op_ready;
    assign w_cnt_clear = (r_state == S_CLEAR);
    assign w_product   = DATA_WIDTH'(a_data) * DATA_WIDTH'(b_data);
    assign w_final_dot = r_dot_valid && (r_row_idx == IW'(M_SIZE - 1))
                                     && (r_col_idx == IW'(M_SIZE - 1));

    matrix_index_counter #(
        .M_SIZE (M_SIZE)
    ) u_index_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (w_cnt_clear),
        .step     (w_accept),
        .k        (w_k),
        .col      (w_col),
        .row      (w_row),
        .last_k   (w_last_k),
        .last_all (w_last_all)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op_ready <= 1'b0;
            r_clear    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_clear <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_CLEAR;
                        r_clear <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state    <= S_RUN;
                    r_op_ready <= 1'b1;
                end
                S_RUN: begin
                    if (w_accept && w_last_all) begin
                        r_state    <= S_DRAIN;
                        r_op_ready <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (w_final_dot) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_op_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Term issue plus a two-stage delay so dot_valid lines up with the accumulator output
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_result    <= '0;
            r_enable    <= 1'b1;
            r_listo     <= 1'b0;
            r_iss_last  <= 1'b0;
            r_iss_row   <= '0;
            r_iss_col   <= '0;
            r_dly_last  <= 1'b0;
            r_dly_row   <= '0;
            r_dly_col   <= '0;
            r_dot_valid <= 1'b0;
            r_row_idx   <= '0;
            r_col_idx   <= '0;
        end else begin
            if (w_accept) begin
                r_result <= w_product;
                r_enable <= (w_k != '0);
                r_listo  <= (w_k != '0);
            end else begin
                r_result <= '0;
                r_enable <= 1'b1;
                r_listo  <= 1'b0;
            end
            r_iss_last  <= w_accept && w_last_k;
            r_iss_row   <= w_row;
            r_iss_col   <= w_col;
            r_dly_last  <= r_iss_last;
            r_dly_row   <= r_iss_row;
            r_dly_col   <= r_iss_col;
            r_dot_valid <= r_dly_last;
            if (r_dly_last) begin
                r_row_idx <= r_dly_row;
                r_col_idx <= r_dly_col;
            end
        end
    end

    assign op_ready  = r_op_ready;
    assign clear     = r_clear;
    assign enable    = r_enable;
    assign listo     = r_listo;
    assign result    = r_result;
    assign dot_valid = r_dot_valid;
    assign row_idx   = r_row_idx;
    assign col_idx   = r_col_idx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: doc/matrix_term_issuer.md
MATRIX_TERM_ISSUER -- requirements
Module: matrix_term_issuer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the result/product width.
REQ-002 Parameter VAR_WIDTH, default 8, SHALL set the operand width.
REQ-003 Parameter M_SIZE, default 4, SHALL set the square matrix dimension; legal values are >=2.
REQ-004 Port clock, input, 1: single rising-edge clock.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port start, input, 1: one-cycle request to begin an M_SIZE x M_SIZE product.
REQ-007 Port op_valid, input, 1: a_data/b_data hold one valid operand pair.
REQ-008 Port a_data, input, VAR_WIDTH: unsigned row element A[row][k].
REQ-009 Port b_data, input, VAR_WIDTH: unsigned column element B[k][col].
REQ-010 Port op_ready, output, 1: operand pair is accepted on cycles where op_valid && op_ready.
REQ-011 Port clear, output, 1: accumulator clear strobe.
REQ-012 Port enable, output, 1: accumulator control.
REQ-013 Port listo, output, 1: accumulator add qualifier.
REQ-014 Port result, output, DATA_WIDTH: product term to the accumulator.
REQ-015 Port dot_valid, output, 1: accumulator output holds a finished dot product.
REQ-016 Port row_idx / col_idx, output, $clog2(M_SIZE) each: element index for the dot_valid pulse.
REQ-017 Port busy, output, 1: high in every state except IDLE.
REQ-018 Port done, output, 1: one-cycle pulse after the final element's dot_valid.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, RUN, DRAIN.
REQ-020 IDLE -> CLEAR on start; start SHALL be ignored in all other states.
REQ-021 CLEAR SHALL last exactly one cycle with clear=1, then go to RUN; counters k, col, row SHALL be zeroed.
REQ-022 In RUN, op_ready SHALL be 1; in every other state it SHALL be 0.
REQ-023 An accepted pair SHALL register result = a_data * b_data (unsigned, zero-extended to DATA_WIDTH) one cycle after acceptance, i.e. latency 1.
REQ-024 Issue encoding: term with k==0 drives enable=0 (load); term with k>0 drives enable=1, listo=1 (add); no term issued drives enable=1, listo=0, result=0 (hold).
REQ-025 RUN with op_valid=0 SHALL issue hold next cycle; counters SHALL not advance.
REQ-026 k SHALL increment per accepted pair and wrap to 0 after M_SIZE-1; on wrap col increments; on col wrap row increments.
REQ-027 dot_valid SHALL pulse exactly 2 cycles after the cycle issuing term k==M_SIZE-1, with row_idx/col_idx of that element.
REQ-028 Acceptance of the final pair (row=col=k=M_SIZE-1) SHALL move RUN -> DRAIN; op_ready SHALL drop the following cycle.
REQ-029 DRAIN SHALL issue holds until the final dot_valid, then assert done for one cycle and return to IDLE.
REQ-030 Sums SHALL wrap modulo 2^DATA_WIDTH; no saturation or overflow flag.
REQ-031 In IDLE, outputs SHALL be clear=0, enable=1, listo=0, result=0, dot_valid=0, done=0.

Reset
REQ-032 Asserting reset at any time, including mid-product, SHALL force IDLE, zero all counters and drive outputs to REQ-031 values with busy=0, op_ready=0, indices=0, asynchronously.
REQ-033 After reset deassertion no dot_valid or done SHALL appear until a new start.

Structure
REQ-034 DATA_WIDTH, VAR_WIDTH, M_SIZE defaults and the state enum typedef SHALL live in a shared package matrix_pkg.
REQ-035 The k/col/row nested counter SHALL be one sub-module, matrix_index_counter (inputs: clear, step; outputs: k, col, row, last_k, last_all).
REQ-036 The output pipeline (product register, dot_valid delay line) SHALL be in-line in matrix_term_issuer.

Verification
REQ-037 Reset held, then released, start pulsed -> clear=1 exactly one cycle, then op_ready=1.
REQ-038 Identity A x B with B=all 3, op_valid held high -> 16 dot_valid pulses, each paired with accumulator out=3, done after the 16th.
REQ-039 A=B=all 255 -> each term result=16'hFE01; accumulator out=16'hF804 (wrap of 4*65025).
REQ-040 op_valid low for 5 cycles mid dot product -> 5 hold cycles (enable=1, listo=0), final sums unchanged versus the no-stall run.
REQ-041 start pulsed while busy -> ignored; no second clear; sequence completes normally.
REQ-042 reset asserted at element (1,2), k=2 -> outputs at reset values immediately; a new start reproduces the full correct 16-element result.
